// File: rtl/axi_frame_writer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : axi_frame_writer_if
// Desc     : AXI4 write-only channel bundle (AW/W/B) between frame writer and memory
// Revision : 1.0
// ----------------------------------------------------------------------------
interface axi_frame_writer_if #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [3:0]              awcache;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface
`default_nettype wire

// File: rtl/axi_frame_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : axi_frame_writer
// Desc     : Stages packed pixel words in a FIFO and writes frames to memory as AXI4 INCR bursts
// Revision : 1.0
// ----------------------------------------------------------------------------
module axi_frame_writer #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BURST_LEN      = 16,
  parameter int FIFO_DEPTH     = 32
) (
  input  logic                      axi_clk_i,
  input  logic                      axi_reset_n_i,
  input  logic                      enable_i,
  input  logic                      double_buff_enable_i,
  input  logic [AXI_ADDR_WIDTH-1:0] frame_ptr0_i,
  input  logic [AXI_ADDR_WIDTH-1:0] frame_ptr1_i,
  input  logic [31:0]               pixel_data_i,
  input  logic                      pixel_valid_i,
  output logic                      pixel_ready_o,
  input  logic                      frame_start_i,
  input  logic                      frame_end_i,
  axi_frame_writer_if.master        m_axi,
  output logic                      frame_done_o,
  output logic                      active_buffer_o,
  output logic                      err_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_burst = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_aw   = 2'd1;
  localparam logic [1:0] c_st_w    = 2'd2;
  localparam logic [1:0] c_st_b    = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [AXI_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_idx_q, rd_idx_q;
  logic [CNT_W-1:0]          count_q;
  logic                      in_frame_q, drop_q, end_pending_q;
  logic [AXI_ADDR_WIDTH-1:0] wptr_q, awaddr_q;
  logic [7:0]                awlen_q, beat_q;
  logic                      active_buffer_q, err_q, frame_done_q;

  logic                      w_full, w_accept, w_start_en, w_start_dis;
  logic                      w_push, w_pop, w_issue, w_b_hs, w_last_beat, w_done;
  logic [CNT_W-1:0]          w_burst_words;
  logic [AXI_ADDR_WIDTH-1:0] w_base;
  logic                      w_unused;

  assign w_full        = (count_q == c_depth);
  assign pixel_ready_o = axi_reset_n_i & (drop_q | ~w_full);
  assign w_accept      = pixel_valid_i & pixel_ready_o;
  assign w_start_en    = w_accept & ~drop_q & frame_start_i & enable_i;
  assign w_start_dis   = w_accept & ~drop_q & frame_start_i & ~enable_i;
  // Outside a frame (and in DROP) accepted words are discarded, not queued.
  assign w_push        = w_accept & ~drop_q & (frame_start_i ? enable_i : in_frame_q);
  assign w_pop         = (state_q == c_st_w) & m_axi.wready;
  assign w_b_hs        = (state_q == c_st_b) & m_axi.bvalid;
  assign w_last_beat   = (beat_q == awlen_q);
  assign w_burst_words = (count_q >= c_burst) ? c_burst : count_q;
  assign w_issue       = (state_q == c_st_idle) &
                         ((count_q >= c_burst) | (end_pending_q & (count_q != '0)));
  assign w_done        = w_b_hs & end_pending_q & (count_q == '0);
  assign w_base        = active_buffer_q ? frame_ptr1_i : frame_ptr0_i;
  assign w_unused      = ^m_axi.bid;

  always_ff @(posedge axi_clk_i) begin
    if (w_push) mem_q[wr_idx_q] <= pixel_data_i;
  end

  always_ff @(posedge axi_clk_i) begin
    if (!axi_reset_n_i) begin
      wr_idx_q        <= '0;
      rd_idx_q        <= '0;
      count_q         <= '0;
      in_frame_q      <= 1'b0;
      drop_q          <= 1'b0;
      end_pending_q   <= 1'b0;
      wptr_q          <= '0;
      awaddr_q        <= '0;
      awlen_q         <= '0;
      beat_q          <= '0;
      active_buffer_q <= 1'b0;
      err_q           <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      if (w_push) wr_idx_q <= wr_idx_q + PTR_W'(1);
      if (w_pop) begin
        rd_idx_q <= rd_idx_q + PTR_W'(1);
        beat_q   <= beat_q + 8'd1;
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase

      if (w_push && frame_end_i)  in_frame_q <= 1'b0;
      else if (w_start_en)        in_frame_q <= 1'b1;
      else if (w_start_dis)       in_frame_q <= 1'b0;

      if (drop_q) begin
        if (w_accept && frame_end_i) drop_q <= 1'b0;
      end else if (w_start_dis && !frame_end_i) begin
        drop_q <= 1'b1;
      end

      // A new frame start discards any end marker left by the previous frame.
      if (w_push)      end_pending_q <= frame_end_i | (end_pending_q & ~frame_start_i);
      else if (w_done) end_pending_q <= 1'b0;

      if (w_issue) begin
        awaddr_q <= wptr_q;
        awlen_q  <= 8'(w_burst_words - CNT_W'(1));
        beat_q   <= '0;
      end

      // The pointer advances at issue so a restart mid-burst is not overwritten later.
      if (w_start_en)   wptr_q <= w_base;
      else if (w_issue) wptr_q <= wptr_q + AXI_ADDR_WIDTH'({w_burst_words, 2'b00});

      if (w_b_hs && (m_axi.bresp != 2'b00)) err_q <= 1'b1;
      frame_done_q <= w_done;
      if (w_done && double_buff_enable_i) active_buffer_q <= ~active_buffer_q;
    end
  end

  always_ff @(posedge axi_clk_i) begin
    if (!axi_reset_n_i) state_q <= c_st_idle;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: if (w_issue)                state_d = c_st_aw;
      c_st_aw:   if (m_axi.awready)          state_d = c_st_w;
      c_st_w:    if (w_pop && w_last_beat)   state_d = c_st_b;
      c_st_b:    if (m_axi.bvalid)           state_d = c_st_idle;
      default:                               state_d = c_st_idle;
    endcase
  end

  always_comb begin
    m_axi.awvalid = 1'b0;
    m_axi.wvalid  = 1'b0;
    m_axi.wlast   = 1'b0;
    m_axi.bready  = 1'b0;
    case (state_q)
      c_st_aw: m_axi.awvalid = 1'b1;
      c_st_w: begin
        m_axi.wvalid = 1'b1;
        m_axi.wlast  = w_last_beat;
      end
      c_st_b:  m_axi.bready  = 1'b1;
      default: ;
    endcase
  end

  assign m_axi.awid    = {AXI_ID_WIDTH{1'b0}};
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = awlen_q;
  assign m_axi.awsize  = 3'b010;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.wdata   = mem_q[rd_idx_q];
  assign m_axi.wstrb   = 4'hF;

  assign frame_done_o    = frame_done_q;
  assign active_buffer_o = active_buffer_q;
  assign err_o           = err_q;
endmodule
`default_nettype wire

// File: tb/tb_axi_frame_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_axi_frame_writer
// Desc     : Scoreboard bench: a frame-level model predicts bursts, beats and frame_done events
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_axi_frame_writer;
  localparam int BL = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, dbl;
  logic [31:0] ptr0, ptr1;
  logic [31:0] pdata;
  logic        pvalid, pready, fstart, fend;
  logic        frame_done, ab, err;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;

  aw_t         exp_aw[$];
  logic [32:0] exp_w[$];
  logic        exp_done[$];

  int total = 0;
  int bad   = 0;
  int aw_seen = 0;
  int b_count = 0;
  int err_at  = -1;
  bit stall = 0, hold_aw = 0, hold_w = 0, gaps = 0;
  bit model_ab = 0;

  always #5 clk = ~clk;

  axi_frame_writer_if #(.ID_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi_frame_writer #(
    .AXI_ID_WIDTH(1), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32),
    .BURST_LEN(BL), .FIFO_DEPTH(32)
  ) dut (
    .axi_clk_i            (clk),
    .axi_reset_n_i        (rst_n),
    .enable_i             (enable),
    .double_buff_enable_i (dbl),
    .frame_ptr0_i         (ptr0),
    .frame_ptr1_i         (ptr1),
    .pixel_data_i         (pdata),
    .pixel_valid_i        (pvalid),
    .pixel_ready_o        (pready),
    .frame_start_i        (fstart),
    .frame_end_i          (fend),
    .m_axi                (axi),
    .frame_done_o         (frame_done),
    .active_buffer_o      (ab),
    .err_o                (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: DUT presented a transfer, got 1 event, expected 0 (queue empty)", name);
  endtask

  // Monitor: compares every DUT handshake against the scoreboard queues.
  initial begin : monitor
    logic        aw_wait;
    logic [31:0] pa;
    logic [7:0]  pl;
    aw_t         ea;
    logic [32:0] ew;
    logic        ed;
    aw_wait = 1'b0;
    pa = '0;
    pl = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_wait = 1'b0;
      end else begin
        if (axi.awvalid && aw_wait) chk("aw_stable", {axi.awaddr, axi.awlen}, {pa, pl});
        if (axi.awvalid && axi.awready) begin
          aw_seen++;
          chk("aw_attr", {axi.awid, axi.awsize, axi.awburst, axi.awcache},
              {1'b0, 3'd2, 2'd1, 4'd3});
          if (exp_aw.size() == 0) unexpected("aw_extra");
          else begin
            ea = exp_aw.pop_front();
            chk("awaddr", axi.awaddr, ea.addr);
            chk("awlen", axi.awlen, ea.len);
          end
        end
        aw_wait = axi.awvalid && !axi.awready;
        pa = axi.awaddr;
        pl = axi.awlen;
        if (axi.wvalid && axi.wready) begin
          if (exp_w.size() == 0) unexpected("w_extra");
          else begin
            ew = exp_w.pop_front();
            chk("wdata", axi.wdata, ew[31:0]);
            chk("wlast", axi.wlast, ew[32]);
            chk("wstrb", axi.wstrb, 4'hF);
          end
        end
        if (frame_done) begin
          if (exp_done.size() == 0) unexpected("frame_done_extra");
          else begin
            ed = exp_done.pop_front();
            chk("active_buffer_at_done", ab, ed);
          end
        end
      end
    end
  end

  // Slave: ready/response generation with optional random stalls.
  initial begin : slave
    bit w_last_hs, b_hs, rst_now;
    int b_pending;
    b_pending = 0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    axi.bid     = 1'b0;
    forever begin
      @(negedge clk);
      rst_now   = rst_n;
      w_last_hs = axi.wvalid & axi.wready & axi.wlast;
      b_hs      = axi.bvalid & axi.bready;
      @(posedge clk);
      #1;
      if (!rst_now) begin
        b_pending  = 0;
        axi.bvalid = 1'b0;
      end else begin
        if (w_last_hs) b_pending++;
        if (b_hs) begin
          b_pending--;
          b_count++;
          axi.bvalid = 1'b0;
        end
        if (!axi.bvalid && b_pending > 0 && (!stall || $urandom_range(0, 2) == 0)) begin
          axi.bvalid = 1'b1;
          axi.bresp  = (b_count == err_at) ? 2'b10 : 2'b00;
        end
        axi.awready = !hold_aw && (!stall || $urandom_range(0, 1) == 1);
        axi.wready  = !hold_w  && (!stall || $urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input bit s, input bit e);
    int t;
    bit acc;
    t = 0;
    pdata = d; fstart = s; fend = e; pvalid = 1'b1;
    forever begin
      @(negedge clk);
      acc = pready;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 5000) begin
        chk("pixel_accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    pvalid = 1'b0; fstart = 1'b0; fend = 1'b0;
  endtask

  // Frame-level model: full bursts from the base, one shorter tail burst.
  task automatic model_word(input logic [31:0] base, input int n, input int i,
                            input logic [31:0] d);
    int  k, len;
    aw_t a;
    k   = i / BL;
    len = ((n - k * BL) < BL) ? (n - k * BL) : BL;
    if (i % BL == 0) begin
      a.addr = base + 32'(k * BL * 4);
      a.len  = 8'(len - 1);
      exp_aw.push_back(a);
    end
    exp_w.push_back({((i % BL) == len - 1), d});
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_done.size() != 0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("frame_done_seen", exp_done.size(), 0);
    chk("aw_drained", exp_aw.size(), 0);
    chk("w_drained", exp_w.size(), 0);
    exp_aw.delete(); exp_w.delete(); exp_done.delete();
  endtask

  task automatic run_frame(input int n, input bit en, input bit fill);
    logic [31:0] base, d;
    base = model_ab ? ptr1 : ptr0;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      if (en) model_word(base, n, i, d);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_word(d, i == 0, i == n - 1);
      if (fill && i == 31) begin
        @(negedge clk);
        chk("ready_low_when_full", pready, 1'b0);
        hold_aw = 0;
        @(posedge clk);
        #1;
      end
    end
    if (en) begin
      if (dbl) model_ab = !model_ab;
      exp_done.push_back(model_ab);
      wait_done();
    end else begin
      repeat (60) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awvalid"}, axi.awvalid, 1'b0);
    chk({tag, "_wvalid"}, axi.wvalid, 1'b0);
    chk({tag, "_bready"}, axi.bready, 1'b0);
    chk({tag, "_pixel_ready"}, pready, 1'b0);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
    chk({tag, "_active_buffer"}, ab, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  initial begin : stim
    int          aw_before, t;
    logic [31:0] rbase;
    aw_t         a;
    rst_n = 1'b0; enable = 1'b1; dbl = 1'b0;
    ptr0 = 32'h0; ptr1 = 32'h0010_0000;
    pdata = '0; pvalid = 1'b0; fstart = 1'b0; fend = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Words before any frame start must vanish.
    for (int i = 0; i < 3; i++) send_word($urandom, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;

    run_frame(64, 1, 0);
    run_frame(20, 1, 0);
    run_frame(1, 1, 0);

    dbl = 1'b1;
    run_frame(32, 1, 0);
    chk("ab_after_frame1", ab, 1'b1);
    run_frame(32, 1, 0);
    chk("ab_after_frame2", ab, 1'b0);
    dbl = 1'b0;

    stall = 1; gaps = 1; hold_aw = 1;
    ptr0 = 32'h0001_0000;
    run_frame(512, 1, 1);
    stall = 0; gaps = 0;
    chk("err_before_slverr", err, 1'b0);

    err_at = b_count + 1;
    run_frame(64, 1, 0);
    chk("err_after_slverr", err, 1'b1);
    err_at = -1;
    run_frame(32, 1, 0);
    chk("err_sticky", err, 1'b1);

    enable = 1'b0;
    aw_before = aw_seen;
    run_frame(40, 0, 0);
    chk("no_aw_when_disabled", aw_seen, aw_before);
    enable = 1'b1;

    dbl = 1'b1;
    run_frame(16, 1, 0);
    chk("ab_before_reset", ab, 1'b1);
    dbl = 1'b0;

    // Park the DUT mid-W, then reset it.
    hold_w = 1;
    rbase = model_ab ? ptr1 : ptr0;
    a.addr = rbase;
    a.len  = 8'd15;
    exp_aw.push_back(a);
    for (int i = 0; i < 18; i++) send_word($urandom, i == 0, 1'b0);
    t = 0;
    while (t < 200) begin
      @(negedge clk);
      if (axi.wvalid) break;
      t++;
    end
    chk("reached_w_phase", axi.wvalid, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midw_reset");
    exp_aw.delete(); exp_w.delete(); exp_done.delete();
    model_ab = 0;
    hold_w = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_frame(24, 1, 0);
    chk("ab_after_reset_frame", ab, 1'b0);
    chk("err_after_reset_frame", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
